tisc_ctrl: RTL and testbench

TISC_CTRL -- requirements
Module: tisc_ctrl

---
 rtl/tisc_pkg.sv | 41 ++++
 rtl/tisc_ctrl_if.sv | 31 +++
 rtl/tisc_ctrl_decode.sv | 31 +++
 rtl/tisc_ctrl.sv | 126 ++++++++++++
 tb/tb_tisc_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tisc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tisc_pkg : shared types and codes for the TISC control unit               |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package tisc_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      CLS_ALU = 3'd0,
      CLS_LD  = 3'd1,
      CLS_ST  = 3'd2,
      CLS_NOP = 3'd3,
      CLS_HLT = 3'd4,
      CLS_ILL = 3'd5
   } iclass_e;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h4;
   localparam logic [3:0] OP_LD  = 4'h5;
   localparam logic [3:0] OP_ST  = 4'h6;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/tisc_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tisc_ctrl_if : datapath <-> controller signal bundle                     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface tisc_ctrl_if;
   logic        run;
   logic [3:0]  opcode;
   logic [1:0]  alu_sel;
   logic        reg_write_en;
   logic        mem_write_en;
   logic        mem_to_reg;
   logic        mem_op;
   logic        pc_en;
   logic        halted;
   logic        illegal;
   logic [15:0] instr_count;

   modport master (
      output run, opcode,
      input  alu_sel, reg_write_en, mem_write_en, mem_to_reg, mem_op,
             pc_en, halted, illegal, instr_count
   );

   modport slave (
      input  run, opcode,
      output alu_sel, reg_write_en, mem_write_en, mem_to_reg, mem_op,
             pc_en, halted, illegal, instr_count
   );
endinterface
`default_nettype wire

// File: rtl/tisc_ctrl_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tisc_ctrl_decode : opcode -> instruction class and ALU select (comb.)    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tisc_ctrl_decode
   import tisc_pkg::*;
(
   input  logic [3:0] opcode,
   output iclass_e    cls,
   output logic [1:0] alu_sel
);

   always_comb begin
      cls     = CLS_ILL;
      alu_sel = ALU_ADD;
      case (opcode)
         OP_NOP: cls = CLS_NOP;
         OP_ADD: begin cls = CLS_ALU; alu_sel = ALU_ADD; end
         OP_SUB: begin cls = CLS_ALU; alu_sel = ALU_SUB; end
         OP_AND: begin cls = CLS_ALU; alu_sel = ALU_AND; end
         OP_OR:  begin cls = CLS_ALU; alu_sel = ALU_OR;  end
         OP_LD:  cls = CLS_LD;
         OP_ST:  cls = CLS_ST;
         OP_HLT: cls = CLS_HLT;
         default: cls = CLS_ILL;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/tisc_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tisc_ctrl : multi-cycle TISC control FSM. Define TISC_CTRL_PERF_EN to     |
// | build the retired-instruction counter. Rev 1.0                            |
// +--------------------------------------------------------------------------+
module tisc_ctrl
   import tisc_pkg::*;
#(
   parameter int MEM_WAIT = 1
) (
   input  logic        clk,
   input  logic        rst,
   tisc_ctrl_if.slave  bus
);

   localparam logic [3:0] C_MEM_WAIT = 4'(MEM_WAIT);

   state_e     state_q, state_d;
   logic [3:0] op_q, op_d;
   logic [3:0] cnt_q, cnt_d;
   logic       illegal_q, illegal_d;

   iclass_e    cls;
   logic [1:0] alu_code;
   logic       mem_last;
   logic       pc_en;

   tisc_ctrl_decode u_decode (
      .opcode  (op_q),
      .cls     (cls),
      .alu_sel (alu_code)
   );

   assign mem_last = (cnt_q == 4'd1);

   // op_q is captured on the FETCH->DECODE edge so DECODE-cycle outputs
   // come from a register rather than the live opcode bus.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      illegal_d = illegal_q;
      case (state_q)
         ST_FETCH: begin
            if (bus.run) begin
               state_d = ST_DECODE;
               op_d    = bus.opcode;
            end
         end
         ST_DECODE: begin
            case (cls)
               CLS_ALU: state_d = ST_EXEC;
               CLS_LD, CLS_ST: begin
                  state_d = ST_MEM;
                  cnt_d   = C_MEM_WAIT;
               end
               CLS_HLT: state_d = ST_HALT;
               CLS_ILL: begin
                  state_d   = ST_FETCH;
                  illegal_d = 1'b1;
               end
               default: state_d = ST_FETCH;
            endcase
         end
         ST_EXEC: state_d = ST_WB;
         ST_MEM: begin
            if (mem_last) begin
               state_d = (cls == CLS_LD) ? ST_WB : ST_FETCH;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_WB:   state_d = ST_FETCH;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_FETCH;
         op_q      <= 4'd0;
         cnt_q     <= 4'd0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
      end
   end

   assign pc_en = (state_q == ST_WB)
               || (state_q == ST_MEM && mem_last && cls == CLS_ST)
               || (state_q == ST_DECODE && (cls == CLS_NOP || cls == CLS_ILL));

   assign bus.alu_sel      = (state_q == ST_EXEC || state_q == ST_WB) ? alu_code : ALU_ADD;
   assign bus.reg_write_en = (state_q == ST_WB);
   assign bus.mem_op       = (state_q == ST_MEM) || (state_q == ST_WB && cls == CLS_LD);
   assign bus.mem_to_reg   = (state_q == ST_WB && cls == CLS_LD);
   assign bus.mem_write_en = (state_q == ST_MEM && mem_last && cls == CLS_ST);
   assign bus.pc_en        = pc_en;
   assign bus.halted       = (state_q == ST_HALT);
   assign bus.illegal      = illegal_q;

`ifdef TISC_CTRL_PERF_EN
   logic [15:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (pc_en) count_d = count_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= 16'd0;
      else     count_q <= count_d;
   end

   assign bus.instr_count = count_q;
`else
   assign bus.instr_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tisc_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tisc_ctrl : randomized bench for tisc_ctrl against a cycle-list model |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_tisc_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       run;
   logic [3:0] opcode;

   int   n_cmp = 0;
   int   n_err = 0;
   logic model_ill;
   int   exp_cnt;

   tisc_ctrl_if if1 ();
   tisc_ctrl_if if3 ();

   assign if1.run    = run;
   assign if1.opcode = opcode;
   assign if3.run    = run;
   assign if3.opcode = opcode;

   tisc_ctrl #(.MEM_WAIT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
   tisc_ctrl #(.MEM_WAIT(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

   always #5 clk = ~clk;

   // {alu_sel[1:0], reg_write_en, mem_write_en, mem_to_reg, mem_op, pc_en, halted, illegal}
   logic [8:0] v1, v3;
   assign v1 = {if1.alu_sel, if1.reg_write_en, if1.mem_write_en, if1.mem_to_reg,
                if1.mem_op, if1.pc_en, if1.halted, if1.illegal};
   assign v3 = {if3.alu_sel, if3.reg_write_en, if3.mem_write_en, if3.mem_to_reg,
                if3.mem_op, if3.pc_en, if3.halted, if3.illegal};

   function automatic bit perf_en();
`ifdef TISC_CTRL_PERF_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   // 0 ALU, 1 LD, 2 ST, 3 NOP, 4 HLT, 5 illegal
   function automatic int op_cls(input logic [3:0] op);
      if (op >= 4'h1 && op <= 4'h4) return 0;
      if (op == 4'h5) return 1;
      if (op == 4'h6) return 2;
      if (op == 4'h0) return 3;
      if (op == 4'hF) return 4;
      return 5;
   endfunction

   function automatic int instr_len(input logic [3:0] op, input int mw);
      case (op_cls(op))
         0: return 4;
         1: return 3 + mw;
         2: return 2 + mw;
         default: return 2;
      endcase
   endfunction

   // Expected outputs k cycles after the instruction's FETCH cycle.
   function automatic logic [8:0] exp_vec(input logic [3:0] op, input int k,
                                          input int mw, input logic ill);
      logic [8:0] v;
      v = '0;
      case (op_cls(op))
         0: begin
            if (k == 2 || k == 3) v[8:7] = 2'(op - 4'd1);
            if (k == 3) begin v[6] = 1'b1; v[2] = 1'b1; end
         end
         1: begin
            if (k >= 2 && k <= 2 + mw) v[3] = 1'b1;
            if (k == 2 + mw) begin v[4] = 1'b1; v[6] = 1'b1; v[2] = 1'b1; end
         end
         2: begin
            if (k >= 2 && k <= 1 + mw) v[3] = 1'b1;
            if (k == 1 + mw) begin v[5] = 1'b1; v[2] = 1'b1; end
         end
         3, 5: if (k == 1) v[2] = 1'b1;
         4: if (k >= 2) v[1] = 1'b1;
         default: ;
      endcase
      v[0] = ill;
      return v;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; run = 1'b0; opcode = 4'h0;
      @(negedge clk);
      rst = 1'b0;
      model_ill = 1'b0;
      exp_cnt = 0;
   endtask

   // One instruction on the MEM_WAIT=3 instance; run may drop after FETCH.
   task automatic run_instr(input logic [3:0] op, input bit drop_run);
      int len;
      len = instr_len(op, 3);
      for (int k = 0; k < len; k++) begin
         logic [8:0] e;
         @(negedge clk);
         e = exp_vec(op, k, 3, model_ill);
         n_cmp++;
         if (v3 !== e) begin
            n_err++;
            $display("FAIL instr op=%h cyc=%0d: got %b want %b", op, k, v3, e);
         end
         n_cmp++;
         if (if3.instr_count !== 16'(exp_cnt)) begin
            n_err++;
            $display("FAIL instr_count op=%h cyc=%0d: got %h want %h", op, k,
                     if3.instr_count, 16'(exp_cnt));
         end
         if (e[2] && perf_en()) exp_cnt++;
         opcode = op;
         run = (k == 0) ? 1'b1 : (drop_run ? 1'($urandom_range(0, 1)) : 1'b1);
      end
      if (op_cls(op) == 5) model_ill = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         n_cmp++;
         if (v3 !== {8'd0, model_ill}) begin
            n_err++;
            $display("FAIL idle cyc=%0d: got %b want %b", i, v3, {8'd0, model_ill});
         end
         run = 1'b0;
         opcode = 4'($urandom_range(0, 15));
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; run = 1'b1; opcode = 4'h1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (v1 !== 9'd0 || v3 !== 9'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got %b/%b want 0", v1, v3);
      end
      n_cmp++;
      if (if1.instr_count !== 16'd0 || if3.instr_count !== 16'd0) begin
         n_err++;
         $display("FAIL reset_count: got %h/%h want 0", if1.instr_count, if3.instr_count);
      end
      run = 1'b0;
      rst = 1'b0;
      model_ill = 1'b0;
      exp_cnt = 0;
   endtask

   // ALU ops back-to-back on both instances; timing is MEM_WAIT independent.
   task automatic test_alu_back_to_back();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         logic [3:0] op;
         op = 4'($urandom_range(1, 4));
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (v1 !== exp_vec(op, k, 1, 1'b0)) begin
               n_err++;
               $display("FAIL alu_mw1 op=%h cyc=%0d: got %b want %b", op, k, v1,
                        exp_vec(op, k, 1, 1'b0));
            end
            n_cmp++;
            if (v3 !== exp_vec(op, k, 3, 1'b0)) begin
               n_err++;
               $display("FAIL alu_mw3 op=%h cyc=%0d: got %b want %b", op, k, v3,
                        exp_vec(op, k, 3, 1'b0));
            end
            n_cmp++;
            if (if1.instr_count !== 16'(exp_cnt)) begin
               n_err++;
               $display("FAIL alu_count: got %h want %h", if1.instr_count, 16'(exp_cnt));
            end
            if (k == 3 && perf_en()) exp_cnt++;
            opcode = op;
            run = 1'b1;
         end
      end
   endtask

   task automatic test_ld();
      do_reset();
      run_instr(4'h5, 1'b0);
      run_instr(4'h5, 1'b1);
   endtask

   task automatic test_st();
      do_reset();
      run_instr(4'h6, 1'b0);
      run_instr(4'h6, 1'b1);
      run_instr(4'h1, 1'b1);
   endtask

   task automatic test_illegal_halt();
      do_reset();
      run_instr(4'h9, 1'b0);
      run_instr(4'hF, 1'b0);
      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         n_cmp++;
         if (v3 !== 9'b0_0000_0011) begin
            n_err++;
            $display("FAIL halt cyc=%0d: got %b want 000000011", i, v3);
         end
         run = 1'b1;
         opcode = 4'($urandom_range(0, 15));
      end
      n_cmp++;
      if (if3.instr_count !== 16'(exp_cnt)) begin
         n_err++;
         $display("FAIL halt_count: got %h want %h", if3.instr_count, 16'(exp_cnt));
      end
   endtask

   task automatic test_reset_mid_st();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_cmp++;
         if (v3 !== exp_vec(4'h6, k, 3, 1'b0)) begin
            n_err++;
            $display("FAIL st_pre_rst cyc=%0d: got %b want %b", k, v3,
                     exp_vec(4'h6, k, 3, 1'b0));
         end
         opcode = 4'h6;
         run = 1'b1;
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if (v3 !== 9'd0 || if3.instr_count !== 16'd0) begin
         n_err++;
         $display("FAIL rst_mid_outputs: got %b cnt %h want 0", v3, if3.instr_count);
      end
      @(negedge clk);
      n_cmp++;
      if (v3 !== 9'd0) begin
         n_err++;
         $display("FAIL rst_mid_held: got %b want 0", v3);
      end
      run = 1'b0;
      rst = 1'b0;
      model_ill = 1'b0;
      exp_cnt = 0;
      idle(2);
      run_instr(4'h0, 1'b0);
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
         run_instr(4'($urandom_range(0, 14)), 1'b1);
      end
   endtask

   task automatic test_count();
      do_reset();
`ifdef TISC_CTRL_PERF_EN
      @(negedge clk);
      opcode = 4'h0;
      run = 1'b1;
      repeat (2 * 65537) @(negedge clk);
      n_cmp++;
      if (if3.instr_count !== 16'h0001) begin
         n_err++;
         $display("FAIL count_wrap: got %h want 0001", if3.instr_count);
      end
`else
      for (int i = 0; i < 100; i++) run_instr(4'h0, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (if3.instr_count !== 16'h0000) begin
         n_err++;
         $display("FAIL count_disabled: got %h want 0000", if3.instr_count);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_alu_back_to_back();
      test_ld();
      test_st();
      test_illegal_halt();
      test_reset_mid_st();
      test_random();
      test_count();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
